// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned RegIdxW = 5;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLdStall = 2'b01,
    StMemWait = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic [RegIdxW-1:0] rd;
    logic               we;
    logic               ld;
  } stage_t;

  // Newest producer wins; x0 and unused operands always read the regfile.
  function automatic logic [1:0] fwd_sel(logic [RegIdxW-1:0] rs, logic use_rs,
                                         stage_t ex, stage_t mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_rs && (rs != '0)) begin
      if (ex.we && (ex.rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (mem.we && (mem.rd == rs)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One {rd, we, ld} shadow pipeline stage with hold and bubble control.
module hz_stage_reg
  import hazard_ctrl_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   hold_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (!hold_i) begin
      if (bubble_i) begin
        q_d = '0;
      end else begin
        q_d    = d_i;
        // Writes to x0 are discarded so they never forward or stall.
        q_d.we = d_i.we & (d_i.rd != '0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, redirect flush, memory-wait hold and operand forwarding control.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RegIdxW-1:0] id_rs1,
  input  logic [RegIdxW-1:0] id_rs2,
  input  logic               id_use1,
  input  logic               id_use2,
  input  logic [RegIdxW-1:0] id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               ex_redirect,
  input  logic               mem_busy,
  output logic               pc_stall,
  output logic               if_id_hold,
  output logic               id_ex_bubble,
  output logic               if_id_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [RegIdxW-1:0] wb_rd,
  output logic               wb_we,
  output logic [15:0]        stall_cnt
);

  state_e state_q, state_d, ret_q, ret_d, eff_state;
  stage_t id_s, ex_s, mem_s, wb_s;
  logic   load_use;
  logic   [1:0] fwd_a_q, fwd_b_q;
  logic   [15:0] stall_cnt_q;

  assign id_s = '{rd: id_rd, we: id_reg_write, ld: id_mem_read};

  hz_stage_reg u_ex (
    .clk_i    (clk),
    .rst_i    (rst),
    .hold_i   (mem_busy),
    .bubble_i (!(id_valid && !id_ex_bubble)),
    .d_i      (id_s),
    .q_o      (ex_s)
  );

  hz_stage_reg u_mem (
    .clk_i    (clk),
    .rst_i    (rst),
    .hold_i   (mem_busy),
    .bubble_i (1'b0),
    .d_i      (ex_s),
    .q_o      (mem_s)
  );

  hz_stage_reg u_wb (
    .clk_i    (clk),
    .rst_i    (rst),
    .hold_i   (mem_busy),
    .bubble_i (1'b0),
    .d_i      (mem_s),
    .q_o      (wb_s)
  );

  assign load_use = ex_s.ld && ex_s.we && id_valid &&
                    ((id_use1 && (id_rs1 == ex_s.rd)) || (id_use2 && (id_rs2 == ex_s.rd)));

  // MEMWAIT behaves as the state it interrupted once mem_busy drops.
  assign eff_state = (state_q == StMemWait) ? ret_q : state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      ret_q   <= StRun;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (mem_busy) begin
      state_d = StMemWait;
      ret_d   = eff_state;
    end else begin
      ret_d = StRun;
      case (eff_state)
        StRun:     state_d = (load_use && !ex_redirect) ? StLdStall : StRun;
        StLdStall: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall   = 1'b1;
        if_id_hold = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if ((eff_state == StRun) && load_use) begin
        pc_stall     = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      if (!mem_busy) begin
        fwd_a_q <= fwd_sel(id_rs1, id_use1, ex_s, mem_s);
        fwd_b_q <= fwd_sel(id_rs2, id_use2, ex_s, mem_s);
      end
      if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign wb_rd     = wb_s.rd;
  assign wb_we     = wb_s.we;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The interface SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, async active-high reset.
REQ-002 The block SHALL have these ID-stage inputs: id_valid in 1, ID holds a real instruction; id_rs1/id_rs2 in 5 each, source register indices; id_use1/id_use2 in 1 each, source actually read; id_rd in 5, destination index; id_reg_write in 1, instruction writes rd; id_mem_read in 1, instruction is a load.
REQ-003 The block SHALL have these pipeline inputs: ex_redirect in 1, branch/jump/jalr taken in EX; mem_busy in 1, data memory not ready, whole pipe must hold.
REQ-004 The block SHALL have these combinational control outputs: pc_stall out 1; if_id_hold out 1; id_ex_bubble out 1; if_id_flush out 1.
REQ-005 The block SHALL have these registered outputs: fwd_a/fwd_b out 2 each, EX operand select (00 regfile, 01 EX/MEM, 10 MEM/WB); wb_rd out 5 and wb_we out 1, regfile write port control; stall_cnt out 16, saturating count of stall cycles.

Function
REQ-006 The block SHALL keep shadow stage registers EX, MEM and WB, each holding {rd, we, ld}; rd==0 SHALL force we=0 at capture.
REQ-007 The FSM SHALL have states RUN, LDSTALL and MEMWAIT.
REQ-008 Load-use SHALL be defined as EX.ld & EX.we & id_valid & ((id_use1 & id_rs1==EX.rd) | (id_use2 & id_rs2==EX.rd)).
REQ-009 In RUN, when load-use holds and ex_redirect=0 and mem_busy=0, the block SHALL assert pc_stall, if_id_hold and id_ex_bubble in that cycle and go to LDSTALL.
REQ-010 LDSTALL SHALL last exactly one cycle with no stall outputs and SHALL return to RUN; the load has then reached MEM, so the dependent instruction gets fwd=10 on its next-cycle EX entry.
REQ-011 ex_redirect=1 with mem_busy=0 SHALL assert if_id_flush and id_ex_bubble, deassert pc_stall, and override load-use in the same cycle.
REQ-012 mem_busy=1 in any state SHALL assert pc_stall and if_id_hold, hold all shadow registers, fwd outputs and FSM state, and keep id_ex_bubble and if_id_flush at 0. The FSM SHALL enter MEMWAIT and, when mem_busy falls, return to the state held on entry.
REQ-013 Shadow advance SHALL happen on every cycle with mem_busy=0: WB<=MEM, MEM<=EX, EX<=ID fields when id_valid & !id_ex_bubble, else EX<=bubble {0,0,0}.
REQ-014 fwd_a SHALL be registered together with the EX capture: 01 if EX.we & EX.rd==id_rs1, else 10 if MEM.we & MEM.rd==id_rs1, else 00. The newer producer SHALL win, and 00 SHALL be forced when rs1==0 or id_use1=0. fwd_b SHALL follow the same rule on rs2/id_use2.
REQ-015 wb_rd/wb_we SHALL be driven from the WB shadow register, with no added latency.
REQ-016 stall_cnt SHALL increment on each cycle with pc_stall=1 and saturate at 16'hFFFF.

Reset
REQ-017 While rst=1, the block SHALL set FSM=RUN, all shadow registers to 0, fwd_a=fwd_b=00, wb_rd=0, wb_we=0 and stall_cnt=0.
REQ-018 While rst=1, all combinational outputs SHALL read 0.
REQ-019 Reset asserted mid-LDSTALL or mid-MEMWAIT SHALL abort to RUN with no residual stall after release.
REQ-020 The first rising edge after rst deasserts SHALL be a normal RUN cycle.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding (2 bits), the fwd select constants FWD_RF/FWD_EXMEM/FWD_MEMWB, and the register-index width 5.
REQ-022 A single sub-module, hz_stage_reg, SHALL implement one {rd,we,ld} shadow stage with hold and bubble inputs, instanced three times.
REQ-023 Hazard detect and output decode SHALL be combinational logic in hazard_ctrl itself.

Verification
REQ-024 Load-use stall: lw x5 in EX, ID add using rs1=x5 -> one cycle pc_stall=if_id_hold=id_ex_bubble=1, next cycle no stall, then fwd_a=10 and stall_cnt=1.
REQ-025 Back-to-back ALU forwarding: add x3 then sub rs2=x3 -> no stall, fwd_b=01; an instruction two later using x3 -> fwd_b=10.
REQ-026 Redirect during load-use: ex_redirect=1 same cycle as load-use -> if_id_flush=1, id_ex_bubble=1, pc_stall=0, FSM stays RUN.
REQ-027 mem_busy held 3 cycles during LDSTALL -> shadows, fwd and state frozen, stall_cnt +3; after release LDSTALL completes normally.
REQ-028 x0 destination: lw x0 then add rs1=x0 -> no stall, fwd_a=00, wb_we=0 when it reaches WB.
REQ-029 Async reset pulse mid-MEMWAIT, asserted off-edge -> all outputs 0 immediately, RUN after release.
